// File: rtl/cache_pkg.sv
// Shared types and constants for the cache refill path.
package cache_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned OFF_W      = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    BURST,
    DONE
  } refill_state_e;

  // Byte address of the first byte of the line containing addr.
  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(LINE_WORDS * 4 - 1);
  endfunction

endpackage

// File: rtl/cache_refill_ctrl.sv
// Cache line refill engine: takes one miss, bursts the line in from memory,
// writes each beat into the victim way and forwards the missed word.
// Optional feature macro: CRIT_WORD_FIRST_EN (burst starts at the missed word
// and wraps within the line). Default build bursts from the line base.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned WAYS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              miss_valid,
  output logic              miss_ready,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic [WAYS-1:0]   miss_way,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [WAYS-1:0]   way_en,
  output logic [ADDR_W-1:0] way_addr_w,
  output logic [DATA_W-1:0] way_data_w,
  output logic [3:0]        way_wen,
  output logic              refill,
  output logic              fwd_valid,
  output logic [DATA_W-1:0] fwd_data,
  output logic              refill_done
);

  localparam logic [OFF_W-1:0] LastBeat = OFF_W'(LINE_WORDS - 1);

  refill_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WAYS-1:0]   way_q, way_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic              all_beats_q, all_beats_d;
  logic              wr_valid_q, wr_valid_d;
  logic              wr_last_q, wr_last_d;
  logic [OFF_W-1:0]  wr_off_q, wr_off_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic [OFF_W-1:0]  miss_off;
  logic [OFF_W-1:0]  beat_off;
  logic [ADDR_W-1:0] req_addr;

  assign miss_off = addr_q[OFF_W+1:2];

`ifdef CRIT_WORD_FIRST_EN
  // Offset arithmetic is OFF_W wide, so the burst wraps inside the line.
  assign beat_off = miss_off + cnt_q;
  assign req_addr = addr_q & ~ADDR_W'(3);
`else
  assign beat_off = cnt_q;
  assign req_addr = line_base(addr_q);
`endif

  // Next-state, beat capture and FSM-owned outputs.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    way_d       = way_q;
    cnt_d       = cnt_q;
    all_beats_d = all_beats_q;
    wr_valid_d  = 1'b0;
    wr_last_d   = 1'b0;
    wr_off_d    = wr_off_q;
    wr_data_d   = wr_data_q;
    miss_ready  = 1'b0;
    mem_req     = 1'b0;
    mem_addr    = '0;
    refill_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) begin
          addr_d  = miss_addr;
          way_d   = miss_way;
          state_d = REQ;
        end
      end
      REQ: begin
        mem_req  = 1'b1;
        mem_addr = req_addr;
        if (mem_ack) begin
          cnt_d       = '0;
          all_beats_d = 1'b0;
          state_d     = BURST;
        end
      end
      BURST: begin
        // Beat count alone ends the burst; extra beats after the line are dropped.
        if (mem_rvalid && !all_beats_q) begin
          wr_valid_d = 1'b1;
          wr_off_d   = beat_off;
          wr_data_d  = mem_rdata;
          wr_last_d  = (cnt_q == LastBeat);
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == LastBeat) begin
            all_beats_d = 1'b1;
          end
        end
        if (wr_valid_q && wr_last_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        refill_done = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any refill in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      way_q       <= '0;
      cnt_q       <= '0;
      all_beats_q <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_last_q   <= 1'b0;
      wr_off_q    <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      way_q       <= way_d;
      cnt_q       <= cnt_d;
      all_beats_q <= all_beats_d;
      wr_valid_q  <= wr_valid_d;
      wr_last_q   <= wr_last_d;
      wr_off_q    <= wr_off_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Bank write port and forward path, driven from the registered beat.
  always_comb begin
    refill     = wr_valid_q;
    way_en     = wr_valid_q ? way_q : '0;
    way_wen    = wr_valid_q ? 4'hF : 4'h0;
    way_addr_w = wr_valid_q ? {2'b00, addr_q[ADDR_W-1:OFF_W+2], wr_off_q} : '0;
    way_data_w = wr_valid_q ? wr_data_q : '0;
    fwd_valid  = wr_valid_q && (wr_off_q == miss_off);
    fwd_data   = fwd_valid ? wr_data_q : '0;
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl (honours CRIT_WORD_FIRST_EN).
module tb_cache_refill_ctrl;

  localparam int LW  = 4;
  localparam int BIG = 1 << 30;
`ifdef CRIT_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        miss_valid = 1'b0;
  logic        miss_ready;
  logic [31:0] miss_addr = '0;
  logic [1:0]  miss_way = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  way_en;
  logic [31:0] way_addr_w;
  logic [31:0] way_data_w;
  logic [3:0]  way_wen;
  logic        refill;
  logic        fwd_valid;
  logic [31:0] fwd_data;
  logic        refill_done;

  cache_refill_ctrl #(.WAYS(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .miss_valid (miss_valid),
    .miss_ready (miss_ready),
    .miss_addr  (miss_addr),
    .miss_way   (miss_way),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .way_en     (way_en),
    .way_addr_w (way_addr_w),
    .way_data_w (way_data_w),
    .way_wen    (way_wen),
    .refill     (refill),
    .fwd_valid  (fwd_valid),
    .fwd_data   (fwd_data),
    .refill_done(refill_done)
  );

  always #5 clk = ~clk;

  // Model: expected writes with the cycle they must appear in, plus busy windows.
  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
    bit          fwd;
  } wr_t;

  wr_t         wq[$];
  int          e = 0;
  int          total = 0;
  int          bad = 0;
  int          busy_from = -1, busy_to = -1;
  int          req_from = -1, req_to = -1;
  int          done_cyc = -1;
  int          tid = 0;
  logic [31:0] cur_addr = '0;
  logic [1:0]  exp_way = '0;
  logic [31:0] exp_maddr = '0;

  // Observation logs used by the literal checks.
  logic [31:0] log_waddr[$];
  logic [31:0] log_fwd[$];
  int          log_fwd_idx = 0;
  int          log_done_e[$];
  int          log_rise_e[$];
  int          log_req_cycles = 0;
  logic [31:0] log_maddr = '0;
  logic        prev_req = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, e, act, exp);
    end
  endtask

  function automatic bit busy_at(input int c);
    return busy_from >= 0 && c >= busy_from && c <= busy_to;
  endfunction

  function automatic bit req_at(input int c);
    return req_from >= 0 && c >= req_from && c <= req_to;
  endfunction

  function automatic logic [31:0] beat_data(input int off);
    return 32'hD000_0000 | (32'(tid) << 8) | 32'(off);
  endfunction

  // Compare process: every cycle, DUT outputs against the model.
  always @(negedge clk) begin
    bit wr;
    wr = wq.size() > 0 && wq[0].cyc == e;
    cmp("miss_ready", 32'(miss_ready), 32'(!busy_at(e)));
    cmp("mem_req", 32'(mem_req), 32'(req_at(e)));
    if (req_at(e)) cmp("mem_addr", mem_addr, exp_maddr);
    cmp("way_en", 32'(way_en), wr ? 32'(exp_way) : 32'd0);
    cmp("way_wen", 32'(way_wen), wr ? 32'hF : 32'h0);
    cmp("refill", 32'(refill), 32'(wr));
    cmp("refill_done", 32'(refill_done), 32'(e == done_cyc));
    if (wr) begin
      cmp("way_addr_w", way_addr_w, wq[0].addr);
      cmp("way_data_w", way_data_w, wq[0].data);
      cmp("fwd_valid", 32'(fwd_valid), 32'(wq[0].fwd));
      if (wq[0].fwd) cmp("fwd_data", fwd_data, wq[0].data);
      void'(wq.pop_front());
    end else begin
      cmp("fwd_valid_idle", 32'(fwd_valid), 32'd0);
    end
    if (way_en != '0) log_waddr.push_back(way_addr_w);
    if (fwd_valid) begin
      log_fwd.push_back(fwd_data);
      log_fwd_idx = log_waddr.size();
    end
    if (refill_done) log_done_e.push_back(e);
    if (mem_req) begin
      log_maddr = mem_addr;
      log_req_cycles++;
    end
    if (mem_req && !prev_req) log_rise_e.push_back(e);
    prev_req = mem_req;
  end

  task automatic step();
    @(posedge clk);
    e++;
    #1;
  endtask

  task automatic clear_logs();
    log_waddr.delete();
    log_fwd.delete();
    log_done_e.delete();
    log_rise_e.delete();
    log_fwd_idx = 0;
    log_req_cycles = 0;
    log_maddr = '0;
  endtask

  task automatic do_reset();
    wq.delete();
    busy_from = -1;
    req_from = -1;
    done_cyc = -1;
    miss_valid = 1'b0;
    mem_ack = 1'b0;
    mem_rvalid = 1'b0;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  // Present a miss and hold it until the model says the engine is idle.
  task automatic issue_miss(input logic [31:0] addr, input logic [1:0] way);
    int guard = 0;
    miss_valid = 1'b1;
    miss_addr = addr;
    miss_way = way;
    while (busy_at(e) && guard < 300) begin
      step();
      guard++;
    end
    if (guard >= 300) begin
      total++;
      bad++;
      $display("FAIL issue_miss_timeout cyc=%0d got=busy want=idle", e);
    end
    cur_addr = addr;
    exp_way = way;
    exp_maddr = CWF ? (addr & ~32'h3) : (addr & ~32'(LW * 4 - 1));
    busy_from = e + 1;
    busy_to = BIG;
    req_from = e + 1;
    req_to = BIG;
    step();
    miss_valid = 1'b0;
  endtask

  // Stall, ack, then drive beats per pattern (1s after the pattern runs out).
  task automatic burst(input int stall, input logic [15:0] pat, input int plen,
                       input int abort_after);
    int k = 0;
    int i = 0;
    int moff;
    moff = int'(cur_addr[3:2]);
    for (int s = 0; s < stall; s++) begin
      mem_rvalid = s[0];
      mem_rdata = 32'hBAD0_0000 | 32'(s);
      step();
    end
    mem_ack = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hBAD0_FFFF;
    req_to = e;
    step();
    mem_ack = 1'b0;
    mem_rvalid = 1'b0;
    while (k < LW) begin
      logic v;
      int   off;
      v = (i < plen) ? pat[i] : 1'b1;
      i++;
      mem_rvalid = v;
      if (v) begin
        off = CWF ? (moff + k) % LW : k;
        mem_rdata = beat_data(off);
        wq.push_back('{e + 1, ((cur_addr & ~32'(LW * 4 - 1)) >> 2) + 32'(off),
                       beat_data(off), off == moff});
        k++;
        if (k == LW) begin
          done_cyc = e + 2;
          busy_to = e + 2;
        end
      end
      step();
      if (abort_after > 0 && k == abort_after) begin
        do_reset();
        return;
      end
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (e <= done_cyc && guard < 100) begin
      step();
      guard++;
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", e);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ord[4];
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();

    // Basic refill.
    tid = 1;
    clear_logs();
    issue_miss(32'h0000_1238, 2'b10);
    burst(2, 16'hFFFF, 0, 0);
    wait_idle();
    cmp("basic_mem_addr", log_maddr, CWF ? 32'h0000_1238 : 32'h0000_1230);
    cmp("basic_nwrites", 32'(log_waddr.size()), 32'd4);
    if (log_waddr.size() > 0)
      cmp("basic_first_waddr", log_waddr[0], CWF ? 32'h48E : 32'h48C);
    cmp("basic_nfwd", 32'(log_fwd.size()), 32'd1);
    if (log_fwd.size() > 0) cmp("basic_fwd_data", log_fwd[0], 32'hD000_0102);
    cmp("basic_ndone", 32'(log_done_e.size()), 32'd1);

    // Gapped beats.
    tid = 2;
    clear_logs();
    issue_miss(32'h0000_4004, 2'b01);
    burst(1, 16'b1011001, 7, 0);
    wait_idle();
    cmp("gap_nwrites", 32'(log_waddr.size()), 32'd4);

    // Busy: next miss held high through the whole refill.
    tid = 3;
    clear_logs();
    issue_miss(32'h8000_0010, 2'b01);
    miss_valid = 1'b1;
    miss_addr = 32'h8000_0020;
    miss_way = 2'b10;
    burst(0, 16'hFFFF, 0, 0);
    tid = 4;
    issue_miss(32'h8000_0020, 2'b10);
    burst(1, 16'hFFFF, 0, 0);
    wait_idle();
    cmp("busy_ndone", 32'(log_done_e.size()), 32'd2);
    if (log_rise_e.size() > 1 && log_done_e.size() > 0)
      cmp("busy_gap", 32'(log_rise_e[1] - log_done_e[0]), 32'd2);

    // Stall with early rvalid.
    tid = 5;
    clear_logs();
    issue_miss(32'h0000_2000, 2'b10);
    burst(10, 16'hFFFF, 0, 0);
    wait_idle();
    cmp("stall_req_cycles", 32'(log_req_cycles), 32'd11);
    cmp("stall_nwrites", 32'(log_waddr.size()), 32'd4);

    // Wrap: miss offset 3.
    tid = 6;
    clear_logs();
    issue_miss(32'h0000_300C, 2'b01);
    burst(0, 16'hFFFF, 0, 0);
    wait_idle();
    if (CWF) begin
      ord[0] = 32'd3; ord[1] = 32'd0; ord[2] = 32'd1; ord[3] = 32'd2;
    end else begin
      ord[0] = 32'd0; ord[1] = 32'd1; ord[2] = 32'd2; ord[3] = 32'd3;
    end
    cmp("wrap_nwrites", 32'(log_waddr.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < log_waddr.size()) cmp("wrap_order", log_waddr[i] & 32'h3, ord[i]);
    cmp("wrap_fwd_idx", 32'(log_fwd_idx), CWF ? 32'd1 : 32'd4);

    // Reset mid-burst, then a clean refill.
    tid = 7;
    clear_logs();
    issue_miss(32'h0000_1238, 2'b10);
    burst(0, 16'hFFFF, 0, 2);
    cmp("rst_nwrites", 32'(log_waddr.size()), 32'd1);
    cmp("rst_ndone", 32'(log_done_e.size()), 32'd0);
    tid = 8;
    clear_logs();
    issue_miss(32'h0000_5678, 2'b01);
    burst(0, 16'hFFFF, 0, 0);
    wait_idle();
    cmp("recover_ndone", 32'(log_done_e.size()), 32'd1);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
